// File: rtl/ball_fsm.sv
// Pong ball controller: serve / move / game-over FSM with scores.
// Ports: clock, reset_n (async, low); enable freezes all state;
//   frame_tick steps motion; bounce 00 none/01 paddle/10 wall/11 score;
//   restart starts a new game. Outputs: ball position, size, direction,
//   both scores, serving and game_over flags (all registered).
module ball_fsm #(
   parameter int SCREEN_X    = 640,
   parameter int SCREEN_Y    = 480,
   parameter int BALL_SIZE   = 8,
   parameter int STEP        = 1,
   parameter int SERVE_DELAY = 60,
   parameter int WIN_SCORE   = 9
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       frame_tick,
   input  logic [1:0] bounce,
   input  logic       restart,
   output logic [9:0] ball_pos_x,
   output logic [9:0] ball_pos_y,
   output logic [7:0] ball_size_x,
   output logic [7:0] ball_size_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic [3:0] score_1,
   output logic [3:0] score_2,
   output logic       serving,
   output logic       game_over
);

   typedef enum logic [1:0] {SERVE, MOVE, OVER} state_t;

   localparam int CW = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);

   localparam logic [CW-1:0] DELAY  = CW'(SERVE_DELAY);
   localparam logic [9:0]    X0     = 10'(SCREEN_X / 2 - BALL_SIZE / 2);
   localparam logic [9:0]    Y0     = 10'(SCREEN_Y / 2 - BALL_SIZE / 2);
   localparam logic [9:0]    HALF_X = 10'(SCREEN_X / 2);
   localparam logic [9:0]    STEP_V = 10'(STEP);
   localparam logic [3:0]    WIN    = 4'(WIN_SCORE);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          react;

   logic       pad_hit;
   logic       wall_hit;
   logic       nx_dx;
   logic       nx_dy;
   logic       left_side;
   logic       win;
   logic [3:0] s1_inc;
   logic [3:0] s2_inc;

   // A reversal is only honoured once per frame (react flag).
   assign pad_hit   = (bounce == 2'b01) && !react;
   assign wall_hit  = (bounce == 2'b10) && !react;
   assign nx_dx     = dir_x ^ pad_hit;
   assign nx_dy     = dir_y ^ wall_hit;
   assign left_side = ball_pos_x < HALF_X;
   assign s1_inc    = score_1 + 4'd1;
   assign s2_inc    = score_2 + 4'd1;
   assign win       = left_side ? (s2_inc == WIN) : (s1_inc == WIN);

   assign ball_size_x = 8'(BALL_SIZE);
   assign ball_size_y = 8'(BALL_SIZE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SERVE;
         cnt        <= DELAY;
         react      <= 1'b0;
         ball_pos_x <= X0;
         ball_pos_y <= Y0;
         dir_x      <= 1'b1;
         dir_y      <= 1'b1;
         score_1    <= 4'd0;
         score_2    <= 4'd0;
         serving    <= 1'b1;
         game_over  <= 1'b0;
      end else if (enable) begin
         if (restart) begin
            state      <= SERVE;
            cnt        <= DELAY;
            react      <= 1'b0;
            ball_pos_x <= X0;
            ball_pos_y <= Y0;
            score_1    <= 4'd0;
            score_2    <= 4'd0;
            serving    <= 1'b1;
            game_over  <= 1'b0;
         end else begin
            unique case (state)
               SERVE: begin
                  // The tick that finds the counter at 1 only launches.
                  if (frame_tick) begin
                     if (cnt <= CW'(1)) begin
                        state   <= MOVE;
                        serving <= 1'b0;
                     end else begin
                        cnt <= cnt - CW'(1);
                     end
                  end
               end
               MOVE: begin
                  if (bounce == 2'b11) begin
                     // Serve goes toward whoever conceded.
                     if (left_side) score_2 <= s2_inc;
                     else           score_1 <= s1_inc;
                     dir_x      <= !left_side;
                     ball_pos_x <= X0;
                     ball_pos_y <= Y0;
                     cnt        <= DELAY;
                     react      <= 1'b0;
                     state      <= win ? OVER : SERVE;
                     serving    <= !win;
                     game_over  <= win;
                  end else begin
                     dir_x <= nx_dx;
                     dir_y <= nx_dy;
                     // Motion uses the direction after any reversal.
                     if (frame_tick) begin
                        ball_pos_x <= nx_dx ? ball_pos_x + STEP_V
                                            : ball_pos_x - STEP_V;
                        ball_pos_y <= nx_dy ? ball_pos_y + STEP_V
                                            : ball_pos_y - STEP_V;
                     end
                     if (pad_hit || wall_hit) react <= 1'b1;
                     else if (frame_tick)     react <= 1'b0;
                  end
               end
               OVER: begin
               end
               default: state <= SERVE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_fsm.sv
// Self-checking bench for ball_fsm: directed vector table and
// scenarios, then random stimulus against a behavioural model.
module tb_ball_fsm;

   localparam int SD  = 4;
   localparam int SX  = 640;
   localparam int SY  = 480;
   localparam int BS  = 8;
   localparam int STP = 1;
   localparam int WIN = 9;
   localparam int X0  = SX / 2 - BS / 2;
   localparam int Y0  = SY / 2 - BS / 2;

   localparam int P_SERVE = 0;
   localparam int P_MOVE  = 1;
   localparam int P_OVER  = 2;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       frame_tick = 1'b0;
   logic [1:0] bounce = 2'b00;
   logic       restart = 1'b0;
   logic [9:0] ball_pos_x;
   logic [9:0] ball_pos_y;
   logic [7:0] ball_size_x;
   logic [7:0] ball_size_y;
   logic       dir_x;
   logic       dir_y;
   logic [3:0] score_1;
   logic [3:0] score_2;
   logic       serving;
   logic       game_over;

   ball_fsm #(
      .SCREEN_X(SX), .SCREEN_Y(SY), .BALL_SIZE(BS),
      .STEP(STP), .SERVE_DELAY(SD), .WIN_SCORE(WIN)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .frame_tick(frame_tick), .bounce(bounce), .restart(restart),
      .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
      .ball_size_x(ball_size_x), .ball_size_y(ball_size_y),
      .dir_x(dir_x), .dir_y(dir_y),
      .score_1(score_1), .score_2(score_2),
      .serving(serving), .game_over(game_over)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // Behavioural model of the game
   int mx, my, mdx, mdy, ms1, ms2, mph, mwait, mack;

   typedef struct {
      bit       tk;
      bit [1:0] b;
      int       x, y, dx, dy, srv;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_game();
      ms1 = 0; ms2 = 0;
      mx = X0; my = Y0;
      mph = P_SERVE; mwait = SD; mack = 0;
   endtask

   task automatic model_reset();
      model_game();
      mdx = 1; mdy = 1;
   endtask

   task automatic model_step(input bit en, input bit tk,
                             input bit [1:0] b, input bit rs);
      bit hit;
      hit = 0;
      if (en) begin
         if (rs) begin
            model_game();
         end else if (mph == P_SERVE) begin
            if (tk) begin
               if (mwait == 1) mph = P_MOVE;
               else mwait--;
            end
         end else if (mph == P_MOVE) begin
            if (b == 2'd3) begin
               if (mx < SX / 2) begin ms2++; mdx = 0; end
               else begin ms1++; mdx = 1; end
               mx = X0; my = Y0; mack = 0; mwait = SD;
               mph = (ms1 == WIN || ms2 == WIN) ? P_OVER : P_SERVE;
            end else begin
               if (!mack && b == 2'd1) begin mdx = 1 - mdx; hit = 1; end
               if (!mack && b == 2'd2) begin mdy = 1 - mdy; hit = 1; end
               if (tk) begin
                  mx = (mx + (mdx ? STP : -STP) + 1024) % 1024;
                  my = (my + (mdy ? STP : -STP) + 1024) % 1024;
               end
               if (hit) mack = 1;
               else if (tk) mack = 0;
            end
         end
      end
   endtask

   task automatic model_check();
      chk("m.pos_x", ball_pos_x, mx);
      chk("m.pos_y", ball_pos_y, my);
      chk("m.dir_x", dir_x, mdx);
      chk("m.dir_y", dir_y, mdy);
      chk("m.score_1", score_1, ms1);
      chk("m.score_2", score_2, ms2);
      chk("m.serving", serving, mph == P_SERVE);
      chk("m.game_over", game_over, mph == P_OVER);
   endtask

   task automatic cyc(input bit en, input bit tk,
                      input bit [1:0] b, input bit rs);
      @(negedge clock);
      enable = en; frame_tick = tk; bounce = b; restart = rs;
      @(posedge clock);
      model_step(en, tk, b, rs);
      #1;
      model_check();
   endtask

   task automatic tick_until_x(input int t);
      for (int i = 0; i < 1100 && mx != t; i++) cyc(1, 1, 2'd0, 0);
      chk("reach_x", ball_pos_x, t);
   endtask

   task automatic tick_until_y(input int t);
      for (int i = 0; i < 1100 && my != t; i++) cyc(1, 1, 2'd0, 0);
      chk("reach_y", ball_pos_y, t);
   endtask

   task automatic serve_out();
      for (int i = 0; i < 20 && mph == P_SERVE; i++) cyc(1, 1, 2'd0, 0);
      chk("serve_out", serving, 0);
   endtask

   task automatic score_side(input bit right);
      serve_out();
      if (right != (mdx == 1)) cyc(1, 0, 2'd1, 0);
      tick_until_x(right ? SX / 2 : SX / 2 - 1);
      cyc(1, 0, 2'd3, 0);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, ".x"}, ball_pos_x, 316);
      chk({tag, ".y"}, ball_pos_y, 236);
      chk({tag, ".dx"}, dir_x, 1);
      chk({tag, ".dy"}, dir_y, 1);
      chk({tag, ".s1"}, score_1, 0);
      chk({tag, ".s2"}, score_2, 0);
      chk({tag, ".srv"}, serving, 1);
      chk({tag, ".over"}, game_over, 0);
      chk({tag, ".szx"}, ball_size_x, 8);
      chk({tag, ".szy"}, ball_size_y, 8);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      bit en, tk, rs;
      bit [1:0] b;

      // serve: 5 ticks, then paddle held 3 clocks and a tick
      tbl[0] = '{1, 2'd0, 316, 236, 1, 1, 1};
      tbl[1] = '{1, 2'd0, 316, 236, 1, 1, 1};
      tbl[2] = '{1, 2'd0, 316, 236, 1, 1, 1};
      tbl[3] = '{1, 2'd0, 316, 236, 1, 1, 0};
      tbl[4] = '{1, 2'd0, 317, 237, 1, 1, 0};
      tbl[5] = '{0, 2'd1, 317, 237, 0, 1, 0};
      tbl[6] = '{0, 2'd1, 317, 237, 0, 1, 0};
      tbl[7] = '{0, 2'd1, 317, 237, 0, 1, 0};
      tbl[8] = '{1, 2'd0, 316, 238, 0, 1, 0};

      model_reset();
      #12;
      reset_vals("reset");
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         cyc(1, tbl[i].tk, tbl[i].b, 0);
         chk($sformatf("tbl%0d.x", i), ball_pos_x, tbl[i].x);
         chk($sformatf("tbl%0d.y", i), ball_pos_y, tbl[i].y);
         chk($sformatf("tbl%0d.dx", i), dir_x, tbl[i].dx);
         chk($sformatf("tbl%0d.dy", i), dir_y, tbl[i].dy);
         chk($sformatf("tbl%0d.srv", i), serving, tbl[i].srv);
      end

      // left-side score at x=4
      tick_until_x(4);
      cyc(1, 0, 2'd3, 0);
      chk("score.s2", score_2, 1);
      chk("score.s1", score_1, 0);
      chk("score.dx", dir_x, 0);
      chk("score.x", ball_pos_x, 316);
      chk("score.y", ball_pos_y, 236);
      chk("score.srv", serving, 1);

      // build scores 3/5 and park at (400,300)
      for (int k = 0; k < 4; k++) score_side(0);
      for (int k = 0; k < 3; k++) score_side(1);
      chk("build.s1", score_1, 3);
      chk("build.s2", score_2, 5);
      serve_out();
      tick_until_x(390);
      cyc(1, 0, 2'd2, 0);
      tick_until_x(400);
      chk("park.y", ball_pos_y, 300);

      // enable low freezes everything, restart included
      for (int k = 0; k < 4; k++) cyc(0, 1, 2'(k), k == 2);
      chk("freeze.x", ball_pos_x, 400);
      chk("freeze.y", ball_pos_y, 300);
      chk("freeze.s1", score_1, 3);
      chk("freeze.s2", score_2, 5);

      // asynchronous reset mid-move
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      reset_vals("async");
      @(negedge clock);
      reset_n = 1'b1;

      // simultaneous wall bounce and tick at y=470
      serve_out();
      tick_until_y(470);
      chk("wall.dy0", dir_y, 1);
      cyc(1, 1, 2'd2, 0);
      chk("wall.y", ball_pos_y, 469);
      chk("wall.dy", dir_y, 0);

      // game over from the right side
      for (int k = 0; k < 10 && ms1 < 8; k++) score_side(1);
      chk("pre.s1", score_1, 8);
      serve_out();
      if (mdx == 0) cyc(1, 0, 2'd1, 0);
      tick_until_x(630);
      cyc(1, 0, 2'd3, 0);
      chk("over.s1", score_1, 9);
      chk("over.flag", game_over, 1);
      chk("over.srv", serving, 0);
      for (int k = 0; k < 6; k++) cyc(1, 1, 2'($urandom_range(0, 3)), 0);
      chk("hold.s1", score_1, 9);
      chk("hold.x", ball_pos_x, 316);
      chk("hold.flag", game_over, 1);
      cyc(1, 0, 2'd0, 1);
      chk("restart.s1", score_1, 0);
      chk("restart.s2", score_2, 0);
      chk("restart.srv", serving, 1);
      chk("restart.over", game_over, 0);

      // random play against the model
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom % 10) != 0;
         tk = ($urandom % 3) == 0;
         r = int'($urandom % 20);
         b = (r < 12) ? 2'd0 : (r < 16) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
         rs = ($urandom % 100) == 0;
         cyc(en, tk, b, rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ball_fsm.md
BALL_FSM -- requirements
Module: ball_fsm

Interface
REQ-001 Parameter SCREEN_X, default 640: screen width in pixels.
REQ-002 Parameter SCREEN_Y, default 480: screen height in pixels.
REQ-003 Parameter BALL_SIZE, default 8: ball width and height in pixels.
REQ-004 Parameter STEP, default 1: pixels moved per axis per frame tick.
REQ-005 Parameter SERVE_DELAY, default 60: number of frame ticks the ball is held at centre before moving.
REQ-006 Parameter WIN_SCORE, default 9: score that ends the game.
REQ-007 Ports clock and reset_n: one clock, `clock`; reset `reset_n` is asynchronous and active-low.
REQ-008 Port list (name, direction, width, meaning):
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  freezes all state when low.
- frame_tick  in  1  one-clock pulse per video frame.
- bounce  in  2  bounce event: 00 none, 01 paddle, 10 wall, 11 score.
- restart  in  1  one-clock pulse that starts a new game.
- ball_pos_x  out  10  ball left edge.
- ball_pos_y  out  10  ball top edge.
- ball_size_x  out  8  equals BALL_SIZE.
- ball_size_y  out  8  equals BALL_SIZE.
- dir_x  out  1  1 = moving right.
- dir_y  out  1  1 = moving down.
- score_1  out  4  player 1 (left) score.
- score_2  out  4  player 2 (right) score.
- serving  out  1  high in SERVE.
- game_over  out  1  high in OVER.

Function
REQ-009 State machine SHALL have exactly three states: SERVE, MOVE, OVER.
REQ-010 Centre position SHALL be X0 = SCREEN_X/2 - BALL_SIZE/2 and Y0 = SCREEN_Y/2 - BALL_SIZE/2 (316, 236 with defaults).
REQ-011 While enable=0, no register SHALL change; all other inputs are ignored.
REQ-012 SERVE behaviour:
- Position is held at (X0, Y0).
- Serve counter is loaded with SERVE_DELAY on entry and decremented on each frame_tick.
- The frame_tick that finds the counter at 1 moves the state to MOVE, with no motion on that tick.
- bounce is ignored.
REQ-013 MOVE, on frame_tick: ball_pos_x SHALL change by +STEP if dir_x=1, else -STEP; ball_pos_y by +STEP if dir_y=1, else -STEP; arithmetic is 10-bit unsigned with no clamping.
REQ-014 MOVE, reaction latch:
- A reaction flag allows at most one direction reversal per frame.
- The flag is set when a 01 or 10 event is acted on.
- The flag is cleared on frame_tick, unless a bounce is acted on in that same cycle.
REQ-015 MOVE, bounce=01 with flag clear: dir_x SHALL invert.
REQ-016 MOVE, bounce=10 with flag clear: dir_y SHALL invert.
REQ-017 MOVE, bounce=01 or 10 with flag set: no effect.
REQ-018 Simultaneous bounce 01/10 and frame_tick: the direction SHALL be inverted first, and the motion on that tick uses the new direction.
REQ-019 MOVE, bounce=11 (regardless of flag or frame_tick):
- If ball_pos_x < SCREEN_X/2, score_2 increments; otherwise score_1 increments.
- dir_x is set toward the player who conceded (0 if player 1 conceded, 1 if player 2 conceded); dir_y is unchanged.
- Position returns to (X0, Y0).
- Next state is OVER if the incremented score equals WIN_SCORE, else SERVE.
REQ-020 Scores SHALL never exceed WIN_SCORE; no wrap is possible.
REQ-021 OVER behaviour:
- Position, scores and directions are held.
- bounce and frame_tick are ignored.
- restart clears both scores and enters SERVE.
REQ-022 restart in SERVE or MOVE SHALL also clear scores, recentre the ball and enter SERVE with the counter reloaded; restart takes priority over bounce and frame_tick.
REQ-023 All outputs SHALL be registered; a bounce acted on at edge N is visible on the outputs after edge N.

Reset
REQ-024 On reset_n=0, asynchronously:
- State is SERVE, with the serve counter set to SERVE_DELAY.
- ball_pos_x=X0, ball_pos_y=Y0.
- dir_x=1, dir_y=1.
- score_1=0, score_2=0.
- serving=1, game_over=0, reaction flag cleared.
REQ-025 A reset asserted mid-game SHALL immediately restore the REQ-024 values; normal operation resumes on the first clock edge after reset_n rises.

Verification
REQ-026 Bench SHALL cover these directed scenarios (SERVE_DELAY=4 where stated):
- Serve: SERVE_DELAY=4, reset then 5 frame_ticks -> position stays (316,236) through tick 4, serving drops on tick 4, tick 5 -> (317,237).
- Paddle bounce: MOVE with dir_x=1, bounce=01 held for 3 clocks, then a tick -> dir_x=0 exactly once, x decreases by 1.
- Simultaneous wall bounce: bounce=10 and frame_tick in the same cycle, dir_y=1, y=470 -> dir_y=0, y=469.
- Score: bounce=11 with ball_pos_x=4 -> score_2 +1, dir_x=0, position (316,236), serving=1.
- Game over: score_1=8, bounce=11 with x=630 -> score_1=9, game_over=1; ticks and bounces ignored; restart -> scores 0, serving=1.
- Reset mid-MOVE at (400,300) with scores 3/5 -> all REQ-024 values immediately; enable=0 freezes state across ticks.
